req_prio_arbiter: RTL and testbench
===================================

// Module: req_prio_arbiter
// PURPOSE
//   Shares one resource among N requesters. Selection reuses the 8:3 priority
//   scheme, where the highest set index wins, with an optional round-robin
//   rotation. Each grant is held until the owner drops its request, or until a
//   hold timeout revokes it. Sits in front of any shared datapath and drives
//   its select/enable with a registered one-hot grant and a binary index.
// PARAMETERS
//   N        8   number of requesters (2..8)
//   IW       3   width of gnt_idx; must be >= clog2(N)
//   RR_EN    1   1 = round-robin rotation; 0 = fixed priority (highest index wins)
//   HOLD_MAX 16  max cycles a grant may be held; 0 = timeout disabled
// PORTS
//   clk       in   1   rising-edge clock
//   rst_n     in   1   asynchronous reset, active-low
//   req       in   N   request vector; bit i high = requester i wants the resource
//   gnt       out  N   one-hot grant (all-zero when idle), registered
//   gnt_idx   out  IW  binary index of current owner; 0 when idle
//   gnt_valid out  1   high while any grant is active (OR of gnt)
//   timeout   out  1   one-cycle pulse when a grant is revoked by HOLD_MAX
//   busy      out  1   high in GRANT state
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; gnt=0; gnt_idx=0; gnt_valid=0;
//     timeout=0; busy=0; hold counter=0; mask=0; last=0. All outputs registered.
//   Eligible set: elig = req & ~mask.
//   FSM states: IDLE and GRANT.
//   IDLE:
//     - elig==0 -> stay in IDLE.
//     - elig!=0 at edge t -> at edge t+1 gnt[w]=1, gnt_idx=w, state=GRANT,
//       counter=0, last=w. Request-to-grant latency is 1 cycle.
//   Winner w:
//     - RR_EN=0: highest set index of elig.
//     - RR_EN=1: highest set index strictly below last, searching downward and
//       wrapping from 0 to N-1. If no other bit is set, last itself is eligible.
//     - After reset last=0, so the first RR pick equals the fixed-priority pick.
//   GRANT:
//     - Counter increments each cycle and saturates at HOLD_MAX.
//     - req[gnt_idx]==0 -> next edge: gnt=0, gnt_valid=0, state=IDLE (release).
//     - Else if HOLD_MAX!=0 and counter==HOLD_MAX-1 -> next edge: gnt=0,
//       timeout=1 for 1 cycle, mask[gnt_idx]=1, state=IDLE (revoke).
//     - Release is checked before timeout when both are true on the same edge;
//       a release never raises timeout.
//     - A grant therefore lasts at most HOLD_MAX cycles.
//     - Requests from other requesters are ignored while in GRANT (no preemption).
//   Inter-grant gap: a release or revoke always passes through exactly one IDLE
//     cycle with gnt=0, so back-to-back grants are 1 cycle apart. This gives
//     the datapath a guaranteed dead cycle for mux switching.
//   Mask: mask[i] clears on any edge where req[i]==0, and holds otherwise.
//     A masked requester must deassert req before it can win again.
//   Sampling: req is sampled only at edges and needs no stability between edges.
//   Reset mid-grant: gnt drops asynchronously; no timeout pulse; rotation
//     restarts from last=0.
//   Invariants: gnt is one-hot or zero; gnt_valid==|gnt;
//     gnt_idx==0 whenever gnt==0.
// TESTING
//   T1 fixed: RR_EN=0, req=8'b0010_0110 held -> gnt=8'b0010_0000, gnt_idx=5
//      one cycle later; drop req[5] -> gnt=0 next cycle, then gnt_idx=2.
//   T2 rotation: RR_EN=1, req=8'hFF held, each owner drops its req for one
//      cycle after 2 cycles of grant -> gnt_idx sequence 7,6,5,...,0,7;
//      one IDLE cycle between grants.
//   T3 timeout: HOLD_MAX=4, req=8'h08 held -> gnt[3] for exactly 4 cycles,
//      timeout pulses 1 cycle, gnt=0; no regrant until req[3] goes low then high.
//   T4 release/timeout tie: owner drops req on the cycle the counter hits
//      HOLD_MAX-1 -> release, timeout stays 0, mask stays 0.
//   T5 reset mid-grant: assert rst_n=0 during GRANT -> all outputs 0 without
//      waiting for a clock edge; after release with req=8'h81 -> gnt_idx=7.
//   T6 idle: req=0 for 20 cycles -> gnt_valid=0, busy=0, timeout=0 throughout;
//      check the one-hot invariant every cycle.

Source files
------------

// File: rtl/req_prio_arbiter_if.sv
// Request/grant bundle between the requesters and the arbiter.
// The slave modport is the arbiter side and the master modport is the requester side.
`timescale 1ns/1ps
interface req_prio_arbiter_if #(
  parameter int N  = 8,
  parameter int IW = 3
);
  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_idx;
  logic          gnt_valid;
  logic          timeout;
  logic          busy;

  modport master (output req, input gnt, gnt_idx, gnt_valid, timeout, busy);
  modport slave  (input req, output gnt, gnt_idx, gnt_valid, timeout, busy);
endinterface

// File: rtl/req_prio_arbiter.sv
// Grant-holding arbiter for N requesters.
// It uses highest-index priority, with optional round-robin rotation.
// The owner keeps the grant until it drops its request or until HOLD_MAX cycles
// expire. On expiry the grant is revoked, and the owner stays masked until it
// deasserts its request. Every grant hand-over passes through one idle cycle.
`timescale 1ns/1ps
module req_prio_arbiter #(
  parameter int N        = 8,
  parameter int IW       = 3,
  parameter int RR_EN    = 1,
  parameter int HOLD_MAX = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  req_prio_arbiter_if.slave bus
);

  localparam int            CW       = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0] CNT_SAT  = CW'(HOLD_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);
  localparam logic [N-1:0]  ONE      = N'(1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  mask_q, mask_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] last_q, last_d;
  logic          gnt_valid_q, gnt_valid_d;
  logic          timeout_q, timeout_d;

  logic [N-1:0]  elig;
  logic [IW-1:0] win;
  logic          below;
  logic          owner_req;

  assign elig      = bus.req & ~mask_q;
  assign owner_req = bus.req[idx_q];

  // Winner select: highest eligible index, or rotating downward from the last owner
  always_comb begin
    win   = '0;
    below = 1'b0;
    if (RR_EN != 0) begin
      // Highest eligible index strictly below the last owner
      for (int i = 0; i < N; i++) begin
        if (elig[i] && (IW'(i) < last_q)) begin
          win   = IW'(i);
          below = 1'b1;
        end
      end
      // Wrap: nothing below last, so take the highest eligible (may be last itself)
      if (!below) begin
        for (int i = 0; i < N; i++) begin
          if (elig[i]) win = IW'(i);
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (elig[i]) win = IW'(i);
      end
    end
  end

  // Next-state and output logic for the IDLE/GRANT controller
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mask_d    = mask_q & bus.req;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    last_d    = last_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|elig) begin
          state_d = GRANT;
          cnt_d   = '0;
          gnt_d   = ONE << win;
          idx_d   = win;
          last_d  = win;
        end
      end
      GRANT: begin
        cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
        // Release has priority over revoke, so a release never raises timeout
        if (!owner_req) begin
          state_d = IDLE;
          gnt_d   = '0;
          idx_d   = '0;
        end else if ((HOLD_MAX != 0) && (cnt_q == CNT_LAST)) begin
          state_d   = IDLE;
          gnt_d     = '0;
          idx_d     = '0;
          timeout_d = 1'b1;
          mask_d    = mask_d | gnt_q;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        idx_d   = '0;
      end
    endcase
    gnt_valid_d = |gnt_d;
  end

  // State, grant and bookkeeping registers; reset clears everything immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mask_q      <= '0;
      gnt_q       <= '0;
      idx_q       <= '0;
      last_q      <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mask_q      <= mask_d;
      gnt_q       <= gnt_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.timeout   = timeout_q;
  assign bus.busy      = (state_q == GRANT);

endmodule

// File: tb/tb_req_prio_arbiter.sv
// Directed bench for req_prio_arbiter.
// It uses three instances: fixed priority, round-robin, and round-robin with a
// short hold limit.
`timescale 1ns/1ps
module tb_req_prio_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  req_prio_arbiter_if #(.N(8), .IW(3)) fix_if ();
  req_prio_arbiter_if #(.N(8), .IW(3)) rr_if  ();
  req_prio_arbiter_if #(.N(8), .IW(3)) to_if  ();

  req_prio_arbiter #(.N(8), .IW(3), .RR_EN(0), .HOLD_MAX(16)) u_fix (
    .clk(clk), .rst_n(rst_n), .bus(fix_if.slave));
  req_prio_arbiter #(.N(8), .IW(3), .RR_EN(1), .HOLD_MAX(16)) u_rr (
    .clk(clk), .rst_n(rst_n), .bus(rr_if.slave));
  req_prio_arbiter #(.N(8), .IW(3), .RR_EN(1), .HOLD_MAX(4)) u_to (
    .clk(clk), .rst_n(rst_n), .bus(to_if.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk5(input string tag,
                      input logic [7:0] g, input logic [2:0] ix, input logic v,
                      input logic t, input logic b,
                      input logic [7:0] eg, input logic [2:0] eix, input logic ev,
                      input logic et, input logic eb);
    chk({tag, ".gnt"},       32'(g),  32'(eg));
    chk({tag, ".gnt_idx"},   32'(ix), 32'(eix));
    chk({tag, ".gnt_valid"}, 32'(v),  32'(ev));
    chk({tag, ".timeout"},   32'(t),  32'(et));
    chk({tag, ".busy"},      32'(b),  32'(eb));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] e;
    rst_n = 1'b0;
    fix_if.req = '0;
    rr_if.req  = '0;
    to_if.req  = '0;
    #3;
    chk5("reset.rr",  rr_if.gnt,  rr_if.gnt_idx,  rr_if.gnt_valid,  rr_if.timeout,  rr_if.busy,
         8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    chk5("reset.fix", fix_if.gnt, fix_if.gnt_idx, fix_if.gnt_valid, fix_if.timeout, fix_if.busy,
         8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    #14;
    rst_n = 1'b1;
    tick();

    // T1: fixed priority, highest index wins, release then next winner
    fix_if.req = 8'b0010_0110;
    chk5("t1.pre", fix_if.gnt, fix_if.gnt_idx, fix_if.gnt_valid, fix_if.timeout, fix_if.busy,
         8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk5("t1.grant", fix_if.gnt, fix_if.gnt_idx, fix_if.gnt_valid, fix_if.timeout, fix_if.busy,
         8'h20, 3'd5, 1'b1, 1'b0, 1'b1);
    tick();
    chk5("t1.hold", fix_if.gnt, fix_if.gnt_idx, fix_if.gnt_valid, fix_if.timeout, fix_if.busy,
         8'h20, 3'd5, 1'b1, 1'b0, 1'b1);
    fix_if.req = 8'b0000_0110;
    tick();
    chk5("t1.release", fix_if.gnt, fix_if.gnt_idx, fix_if.gnt_valid, fix_if.timeout, fix_if.busy,
         8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk5("t1.next", fix_if.gnt, fix_if.gnt_idx, fix_if.gnt_valid, fix_if.timeout, fix_if.busy,
         8'h04, 3'd2, 1'b1, 1'b0, 1'b1);
    fix_if.req = '0;
    tick();
    chk5("t1.end", fix_if.gnt, fix_if.gnt_idx, fix_if.gnt_valid, fix_if.timeout, fix_if.busy,
         8'h00, 3'd0, 1'b0, 1'b0, 1'b0);

    // T2: rotation 7,6,...,0,7 with all requesters active
    rr_if.req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      e = 3'(7 - k);
      tick();
      chk5($sformatf("t2.g%0d", k), rr_if.gnt, rr_if.gnt_idx, rr_if.gnt_valid, rr_if.timeout,
           rr_if.busy, 8'(1) << e, e, 1'b1, 1'b0, 1'b1);
      tick();
      chk($sformatf("t2.h%0d.gnt_idx", k), 32'(rr_if.gnt_idx), 32'(e));
      rr_if.req = 8'hFF & ~(8'(1) << e);
      tick();
      chk5($sformatf("t2.gap%0d", k), rr_if.gnt, rr_if.gnt_idx, rr_if.gnt_valid, rr_if.timeout,
           rr_if.busy, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
      rr_if.req = 8'hFF;
    end
    rr_if.req = '0;
    tick();
    chk5("t2.end", rr_if.gnt, rr_if.gnt_idx, rr_if.gnt_valid, rr_if.timeout, rr_if.busy,
         8'h00, 3'd0, 1'b0, 1'b0, 1'b0);

    // T3: hold timeout after 4 cycles, masked until the request toggles
    to_if.req = 8'h08;
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk5($sformatf("t3.c%0d", c), to_if.gnt, to_if.gnt_idx, to_if.gnt_valid, to_if.timeout,
           to_if.busy, 8'h08, 3'd3, 1'b1, 1'b0, 1'b1);
    end
    tick();
    chk5("t3.revoke", to_if.gnt, to_if.gnt_idx, to_if.gnt_valid, to_if.timeout, to_if.busy,
         8'h00, 3'd0, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk5($sformatf("t3.masked%0d", c), to_if.gnt, to_if.gnt_idx, to_if.gnt_valid,
           to_if.timeout, to_if.busy, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    end
    to_if.req = '0;
    tick();
    chk5("t3.unmask", to_if.gnt, to_if.gnt_idx, to_if.gnt_valid, to_if.timeout, to_if.busy,
         8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    to_if.req = 8'h08;
    tick();
    chk5("t3.regrant", to_if.gnt, to_if.gnt_idx, to_if.gnt_valid, to_if.timeout, to_if.busy,
         8'h08, 3'd3, 1'b1, 1'b0, 1'b1);

    // T4: owner drops its request on the last allowed cycle, so this is a release
    tick();
    tick();
    tick();
    chk5("t4.c4", to_if.gnt, to_if.gnt_idx, to_if.gnt_valid, to_if.timeout, to_if.busy,
         8'h08, 3'd3, 1'b1, 1'b0, 1'b1);
    to_if.req = '0;
    tick();
    chk5("t4.release", to_if.gnt, to_if.gnt_idx, to_if.gnt_valid, to_if.timeout, to_if.busy,
         8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    to_if.req = 8'h08;
    tick();
    chk5("t4.nomask", to_if.gnt, to_if.gnt_idx, to_if.gnt_valid, to_if.timeout, to_if.busy,
         8'h08, 3'd3, 1'b1, 1'b0, 1'b1);
    to_if.req = '0;
    tick();
    chk5("t4.end", to_if.gnt, to_if.gnt_idx, to_if.gnt_valid, to_if.timeout, to_if.busy,
         8'h00, 3'd0, 1'b0, 1'b0, 1'b0);

    // T5: asynchronous reset in the middle of a grant, then restart the rotation
    rr_if.req = 8'h10;
    tick();
    chk5("t5.grant", rr_if.gnt, rr_if.gnt_idx, rr_if.gnt_valid, rr_if.timeout, rr_if.busy,
         8'h10, 3'd4, 1'b1, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk5("t5.async", rr_if.gnt, rr_if.gnt_idx, rr_if.gnt_valid, rr_if.timeout, rr_if.busy,
         8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    rr_if.req = 8'h81;
    #2;
    rst_n = 1'b1;
    tick();
    chk5("t5.after", rr_if.gnt, rr_if.gnt_idx, rr_if.gnt_valid, rr_if.timeout, rr_if.busy,
         8'h80, 3'd7, 1'b1, 1'b0, 1'b1);
    rr_if.req = '0;
    tick();
    chk5("t5.end", rr_if.gnt, rr_if.gnt_idx, rr_if.gnt_valid, rr_if.timeout, rr_if.busy,
         8'h00, 3'd0, 1'b0, 1'b0, 1'b0);

    // T6: long idle stretch with invariant checks every cycle
    for (int c = 0; c < 20; c++) begin
      tick();
      chk5($sformatf("t6.idle%0d", c), rr_if.gnt, rr_if.gnt_idx, rr_if.gnt_valid,
           rr_if.timeout, rr_if.busy, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("t6.onehot%0d", c), 32'($onehot0(rr_if.gnt)), 32'd1);
      chk($sformatf("t6.valid_or%0d", c), 32'(rr_if.gnt_valid), 32'(|rr_if.gnt));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
